// File: rtl/placement_pkg.sv
// rtl/placement_pkg.sv - shared op, cell and FSM encodings for grid placement
package placement_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLAIM = 2'd2,
    OP_FREE  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Unoccupied cell marker; users slice it down to their cell width.
  localparam int                    MAX_DATA_W = 64;
  localparam logic [MAX_DATA_W-1:0] EMPTY_CELL = '1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot pick with a next-start pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             take,
  output logic [N_REQ-1:0] gnt
);

  // ptr_q is the index the search starts from, i.e. one after the last winner
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] req_hi;
  logic             hi_any;

  // pick the lowest request at or above the pointer, else wrap to the lowest overall
  always_comb begin
    req_hi  = '0;
    gnt     = '0;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_hi[i] = req[i] && (IDX_W'(i) >= ptr_q);
    end
    hi_any = |req_hi;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (hi_any ? req_hi[i] : req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

  // advance the start point past the winner whenever a grant is taken
  always_comb begin
    ptr_d = ptr_q;
    if (take) begin
      ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // pointer register; reset puts requester 0 first in line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/grid_claim_arbiter.sv
// rtl/grid_claim_arbiter.sv - shared grid RAM port arbiter with atomic cell claim (option: GRID_ARB_STATS_EN)
module grid_claim_arbiter
  import placement_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int GRID_CELLS = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      op,
  input  logic [ADDR_W*N_REQ-1:0] addr,
  input  logic [DATA_W*N_REQ-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ok,
  output logic                    busy,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_din,
  input  logic [DATA_W-1:0]       mem_dout
`ifdef GRID_ARB_STATS_EN
  ,
  output logic [15:0]             stat_claims,
  output logic [15:0]             stat_conflicts
`endif
);

  localparam int                IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DATA_W-1:0] EMPTY = EMPTY_CELL[DATA_W-1:0];
  localparam logic [31:0]       CELLS = GRID_CELLS;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              ok_q, ok_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic              arb_take;
  logic [1:0]        sel_op;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              in_range;
  logic              claim_win;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (arb_take),
    .gnt   (arb_gnt)
  );

  assign arb_take  = (state_q == ST_IDLE) && (|req);
  assign in_range  = 32'(addr_q) < CELLS;
  // The claim wins only on an empty cell, and a placer may never store the empty marker itself.
  assign claim_win = in_range && (mem_dout == EMPTY) && (wdata_q != EMPTY);

  // route the winning requester's op fields to the latch inputs
  always_comb begin
    sel_op    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_op    = op[2*i +: 2];
        sel_addr  = addr[ADDR_W*i +: ADDR_W];
        sel_wdata = wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  // next-state and registered-output logic for the four-phase op sequence
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    ok_d    = ok_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          op_d    = op_e'(sel_op);
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          gnt_d   = arb_gnt;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CHECK;
      ST_CHECK: begin
        state_d = ST_RESP;
        if (!in_range) begin
          ok_d = 1'b0;
        end else begin
          case (op_q)
            OP_READ: begin
              rdata_d = mem_dout;
              ok_d    = 1'b1;
            end
            OP_CLAIM: begin
              rdata_d = mem_dout;
              ok_d    = claim_win;
            end
            default: ok_d = 1'b1;
          endcase
        end
      end
      ST_RESP: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset drops any op in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  // RAM pins decode from the registered state so a reset releases them at once;
  // the claim write sits in CHECK, right behind its own read, with no gap for others.
  always_comb begin
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (state_q == ST_ISSUE && in_range) begin
      mem_addr = addr_q;
      case (op_q)
        OP_READ, OP_CLAIM: mem_re = 1'b1;
        OP_WRITE: begin
          mem_we  = 1'b1;
          mem_din = wdata_q;
        end
        default: begin
          mem_we  = 1'b1;
          mem_din = EMPTY;
        end
      endcase
    end else if (state_q == ST_CHECK && op_q == OP_CLAIM && claim_win) begin
      mem_we   = 1'b1;
      mem_addr = addr_q;
      mem_din  = wdata_q;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign ok    = ok_q;
  assign busy  = (state_q != ST_IDLE);

`ifdef GRID_ARB_STATS_EN
  logic [15:0] stat_claims_q, stat_claims_d;
  logic [15:0] stat_conflicts_q, stat_conflicts_d;

  // tally each claim outcome at its decision cycle, saturating at full scale
  always_comb begin
    stat_claims_d    = stat_claims_q;
    stat_conflicts_d = stat_conflicts_q;
    if (state_q == ST_CHECK && op_q == OP_CLAIM) begin
      if (claim_win) begin
        if (stat_claims_q != 16'hFFFF) stat_claims_d = stat_claims_q + 16'd1;
      end else begin
        if (stat_conflicts_q != 16'hFFFF) stat_conflicts_d = stat_conflicts_q + 16'd1;
      end
    end
  end

  // claim statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_claims_q    <= '0;
      stat_conflicts_q <= '0;
    end else begin
      stat_claims_q    <= stat_claims_d;
      stat_conflicts_q <= stat_conflicts_d;
    end
  end

  assign stat_claims    = stat_claims_q;
  assign stat_conflicts = stat_conflicts_q;
`endif

endmodule

// File: tb/tb_grid_claim_arbiter.sv
// tb/tb_grid_claim_arbiter.sv - directed self-checking bench for grid_claim_arbiter
module tb_grid_claim_arbiter;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [DW-1:0] EMPTY = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [2*N-1:0]  op;
  logic [AW*N-1:0] addr;
  logic [DW*N-1:0] wdata;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  logic            ok, busy, mem_re, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din, mem_dout;

  logic [1:0]      op_a    [4];
  logic [AW-1:0]   addr_a  [4];
  logic [DW-1:0]   wdata_a [4];

  logic [DW-1:0]   ram [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  logic            ph_re   [0:7];
  logic            ph_we   [0:7];
  logic            ph_busy [0:7];
  logic [AW-1:0]   ph_addr [0:7];
  logic [DW-1:0]   ph_din  [0:7];
  logic [N-1:0]    ph_gnt  [0:7];
  logic [N-1:0]    ev_done [0:7];
  logic            ev_ok   [0:7];
  logic [DW-1:0]   ev_rdata[0:7];
  int              ev_cyc  [0:7];
  int              ev_n;
  logic            any_re, any_we, saw_done;

  always #5 clk = ~clk;

  assign op    = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign addr  = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
  assign wdata = {wdata_a[3], wdata_a[2], wdata_a[1], wdata_a[0]};

  grid_claim_arbiter #(
    .N_REQ (N), .ADDR_W (AW), .DATA_W (DW), .GRID_CELLS (100)
  ) dut (
    .clk (clk), .reset (reset), .req (req), .op (op), .addr (addr), .wdata (wdata),
    .gnt (gnt), .done (done), .rdata (rdata), .ok (ok), .busy (busy),
    .mem_re (mem_re), .mem_we (mem_we), .mem_addr (mem_addr), .mem_din (mem_din),
    .mem_dout (mem_dout)
  );

  // grid RAM model: registered read, write on the clock edge
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [1:0] i, input logic [1:0] o, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    op_a[i]    = o;
    addr_a[i]  = a;
    wdata_a[i] = d;
  endtask

  // raise req for mask; drop each requester once granted unless hold; collect n_done completions
  task automatic run(input logic [N-1:0] mask, input logic hold, input int n_done);
    int cyc;
    req = mask; ev_n = 0; any_re = 1'b0; any_we = 1'b0; cyc = 0;
    while (ev_n < n_done && cyc < 4 * n_done + 8) begin
      @(negedge clk);
      if (cyc < 8) begin
        ph_re[3'(cyc)]   = mem_re;
        ph_we[3'(cyc)]   = mem_we;
        ph_busy[3'(cyc)] = busy;
        ph_addr[3'(cyc)] = mem_addr;
        ph_din[3'(cyc)]  = mem_din;
        ph_gnt[3'(cyc)]  = gnt;
      end
      any_re = any_re | mem_re;
      any_we = any_we | mem_we;
      if (!hold) req = req & ~gnt;
      if (done != '0) begin
        ev_done[3'(ev_n)]  = done;
        ev_ok[3'(ev_n)]    = ok;
        ev_rdata[3'(ev_n)] = rdata;
        ev_cyc[3'(ev_n)]   = cyc;
        ev_n++;
      end
      cyc++;
    end
    req = '0;
    check_eq("ops_completed", ev_n, n_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = '0; reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(2'(i), 2'd0, '0, '0);
    for (int i = 0; i < 4096; i++) ram[12'(i)] <= EMPTY;
    repeat (3) @(negedge clk);

    check_eq("rst_gnt",   32'(gnt), 0);
    check_eq("rst_done",  32'(done), 0);
    check_eq("rst_ok",    32'(ok), 0);
    check_eq("rst_busy",  32'(busy), 0);
    check_eq("rst_re_we", 32'({mem_re, mem_we}), 0);
    check_eq("rst_maddr", 32'(mem_addr), 0);
    check_eq("rst_mdin",  mem_din, 0);
    check_eq("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    // single claim by requester 1 on empty cell 23
    set_req(2'd1, 2'd2, 12'd23, 32'd5);
    run(4'b0010, 1'b0, 1);
    check_eq("claim_issue_gnt",  32'(ph_gnt[0]), 32'h2);
    check_eq("claim_issue_busy", 32'(ph_busy[0]), 1);
    check_eq("claim_issue_re",   32'(ph_re[0]), 1);
    check_eq("claim_issue_we",   32'(ph_we[0]), 0);
    check_eq("claim_issue_addr", 32'(ph_addr[0]), 23);
    check_eq("claim_check_re",   32'(ph_re[1]), 0);
    check_eq("claim_check_we",   32'(ph_we[1]), 1);
    check_eq("claim_check_addr", 32'(ph_addr[1]), 23);
    check_eq("claim_check_din",  ph_din[1], 5);
    check_eq("claim_resp_we",    32'(ph_we[2]), 0);
    check_eq("claim_done",       32'(ev_done[0]), 32'h2);
    check_eq("claim_latency",    ev_cyc[0], 3);
    check_eq("claim_ok",         32'(ev_ok[0]), 1);
    check_eq("claim_rdata",      ev_rdata[0], EMPTY);

    set_req(2'd3, 2'd0, 12'd23, 32'd0);
    run(4'b1000, 1'b0, 1);
    check_eq("read23_done",  32'(ev_done[0]), 32'h8);
    check_eq("read23_ok",    32'(ev_ok[0]), 1);
    check_eq("read23_rdata", ev_rdata[0], 5);

    // simultaneous claims of cell 40 by requesters 0 and 2
    set_req(2'd0, 2'd2, 12'd40, 32'd7);
    set_req(2'd2, 2'd2, 12'd40, 32'd9);
    run(4'b0101, 1'b0, 2);
    check_eq("conf_first_done",  32'(ev_done[0]), 32'h1);
    check_eq("conf_first_ok",    32'(ev_ok[0]), 1);
    check_eq("conf_first_rdata", ev_rdata[0], EMPTY);
    check_eq("conf_second_done", 32'(ev_done[1]), 32'h4);
    check_eq("conf_second_ok",   32'(ev_ok[1]), 0);
    check_eq("conf_second_rd",   ev_rdata[1], 7);
    check_eq("conf_spacing",     ev_cyc[1] - ev_cyc[0], 4);
    check_eq("conf_cell",        ram[40], 7);
    set_req(2'd3, 2'd0, 12'd40, 32'd0);
    run(4'b1000, 1'b0, 1);
    check_eq("read40_rdata", ev_rdata[0], 7);

    // all four hold req: strict rotation, one op per four cycles
    for (int i = 0; i < 4; i++) set_req(2'(i), 2'd0, 12'(i), 32'd0);
    run(4'b1111, 1'b1, 8);
    for (int k = 0; k < 8; k++) begin
      check_eq("rr_order", 32'(ev_done[3'(k)]), 32'(1) << (k % 4));
      if (k > 0) check_eq("rr_spacing", ev_cyc[3'(k)] - ev_cyc[3'(k - 1)], 4);
    end

    // range boundary: 100 rejected without touching RAM, 99 accepted
    set_req(2'd0, 2'd2, 12'd100, 32'd12);
    run(4'b0001, 1'b0, 1);
    check_eq("oob_re",   32'(any_re), 0);
    check_eq("oob_we",   32'(any_we), 0);
    check_eq("oob_ok",   32'(ev_ok[0]), 0);
    check_eq("oob_done", 32'(ev_done[0]), 32'h1);
    set_req(2'd1, 2'd2, 12'd99, 32'd13);
    run(4'b0010, 1'b0, 1);
    check_eq("edge99_ok",   32'(ev_ok[0]), 1);
    check_eq("edge99_cell", ram[99], 13);

    // free cell 23, then reclaim it with node 8
    set_req(2'd2, 2'd3, 12'd23, 32'd0);
    run(4'b0100, 1'b0, 1);
    check_eq("free_we",  32'(ph_we[0]), 1);
    check_eq("free_din", ph_din[0], EMPTY);
    check_eq("free_ok",  32'(ev_ok[0]), 1);
    set_req(2'd3, 2'd2, 12'd23, 32'd8);
    run(4'b1000, 1'b0, 1);
    check_eq("reclaim_ok",    32'(ev_ok[0]), 1);
    check_eq("reclaim_rdata", ev_rdata[0], EMPTY);
    check_eq("reclaim_cell",  ram[23], 8);

    // storing the empty marker as a node id is refused
    set_req(2'd0, 2'd2, 12'd60, EMPTY);
    run(4'b0001, 1'b0, 1);
    check_eq("emptyid_ok", 32'(ev_ok[0]), 0);
    check_eq("emptyid_we", 32'(any_we), 0);

    // reset during CHECK, before the write edge
    set_req(2'd1, 2'd2, 12'd50, 32'd11);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    check_eq("rstmid_issue_re", 32'(mem_re), 1);
    @(negedge clk);
    check_eq("rstmid_check_we", 32'(mem_we), 1);
    reset = 1'b0;
    #1;
    check_eq("rstmid_we",    32'(mem_we), 0);
    check_eq("rstmid_gnt",   32'(gnt), 0);
    check_eq("rstmid_busy",  32'(busy), 0);
    check_eq("rstmid_maddr", 32'(mem_addr), 0);
    check_eq("rstmid_mdin",  mem_din, 0);
    check_eq("rstmid_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_done = saw_done | (|done);
    end
    check_eq("rstmid_no_done", 32'(saw_done), 0);
    check_eq("rstmid_cell",    ram[50], EMPTY);
    run(4'b0010, 1'b0, 1);
    check_eq("post_rst_done",  32'(ev_done[0]), 32'h2);
    check_eq("post_rst_ok",    32'(ev_ok[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_claim_arbiter.md
# grid_claim_arbiter

Round-robin arbiter that shares the single placement-grid RAM port among `N_REQ` placement requesters. It provides atomic claim (test-and-set) of grid cells, so parallel placers cannot put two nodes in the same cell. It sits between the placer FSMs and the grid `memoryRAM` instance, and owns that instance's `read`/`write`/`addr`/`dataWrite` pins outright.

## Interface
- `N_REQ`, default 4: number of requesters.
- `ADDR_W`, default 12: grid address width.
- `DATA_W`, default 32: cell width; each cell holds a node id.
- `GRID_CELLS`, default 100: valid cells (n*n); addresses at or above this are out of range.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request level.
- `op` in 2*N_REQ: per-requester op; 0 READ, 1 WRITE, 2 CLAIM, 3 FREE.
- `addr` in ADDR_W*N_REQ: per-requester cell address.
- `wdata` in DATA_W*N_REQ: per-requester node id.
- `gnt` out N_REQ: one-hot, the requester currently served.
- `done` out N_REQ: one-hot, one-cycle completion pulse.
- `rdata` out DATA_W: shared cell value, valid with `done`.
- `ok` out 1: op succeeded, valid with `done`.
- `busy` out 1: high in any state other than IDLE.
- `mem_re` out 1, `mem_we` out 1, `mem_addr` out ADDR_W, `mem_din` out DATA_W: grid RAM port.
- `mem_dout` in DATA_W: grid RAM read data, valid the cycle after `mem_re`.

## Operation
- FSM states: IDLE, ISSUE, CHECK, RESP.
- IDLE
  - If any `req` is high, pick a winner round-robin, starting one index after the last winner. After reset the search starts at requester 0.
  - Latch the winner's op, addr and wdata; set `gnt`; go to ISSUE.
- ISSUE
  - Out-of-range addr: no memory access for any op; `ok`=0.
  - READ / CLAIM: `mem_re`=1.
  - WRITE: `mem_we`=1, `mem_din`=wdata.
  - FREE: `mem_we`=1, `mem_din`=EMPTY_CELL (all ones, -1).
- CHECK
  - READ: capture `mem_dout` into `rdata`; `ok`=1.
  - CLAIM: `ok`=1 only if `mem_dout`==EMPTY_CELL and wdata!=EMPTY_CELL. In that case `mem_we`=1 with the latched addr and wdata.
  - CLAIM, otherwise: no write, `ok`=0.
  - CLAIM: `rdata` takes the pre-claim cell value.
- RESP: pulse the winner's `done` bit with `rdata`/`ok`; clear `gnt`; go to IDLE.
- `req` is a level. A requester that keeps `req` high after `done` is treated as a new request and competes normally in the next IDLE.
- Changes to `op`/`addr`/`wdata` after the IDLE grant are ignored.
- Requests arriving while busy wait; there is no queueing beyond `req` itself.
- Arithmetic
  - The range check is unsigned, `addr` < `GRID_CELLS`.
  - Cell comparison is full-width `DATA_W` equality.

## Timing
- Fixed 4 cycles per op: IDLE, then ISSUE, then CHECK, then RESP.
- `done` is asserted 3 cycles after the grant edge.
- Back-to-back ops from different requesters run at one per 4 cycles.
- The claim's read and its write are separated by exactly one cycle, and no other requester can touch the RAM in between. This is what makes the claim atomic.
- Reset values: `gnt`, `done`, `ok`, `busy`, `mem_re`, `mem_we` = 0; `mem_addr`, `mem_din`, `rdata` = 0; rr pointer = 0; state IDLE.
- Reset asserted mid-op clears everything immediately and drops the op.
  - A claim reset in ISSUE or CHECK-before-edge never writes.
  - No `done` is issued for a dropped op.

## Configuration
- `GRID_ARB_STATS_EN` defined:
  - Adds outputs `stat_claims` (16) and `stat_conflicts` (16).
  - `stat_claims` counts successful CLAIMs; `stat_conflicts` counts failed CLAIMs.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: neither port nor counters exist, and behaviour is otherwise identical.

## Structure
- `placement_pkg` holds:
  - the op encoding (`OP_READ`=0, `OP_WRITE`=1, `OP_CLAIM`=2, `OP_FREE`=3);
  - `EMPTY_CELL` = all ones;
  - the FSM state encoding.
- Sub-module `rr_arbiter`: combinational one-hot pick from `req` plus a last-winner pointer register updated on grant. The top FSM instantiates it once.

## Test plan
- Single CLAIM: requester 1 claims addr 23 with wdata 5 on an empty cell. `mem_re` in ISSUE, `mem_we` with din 5 in CHECK, `done`=0b0010 with `ok`=1 and `rdata`=-1; a following READ of 23 returns 5 with `ok`=1.
- Conflict: requesters 0 and 2 both CLAIM addr 40 in the same cycle, with wdata 7 and 9. Requester 0 wins with `ok`=1; requester 2 then gets `ok`=0 and `rdata`=7; the cell holds 7.
- Round-robin: all 4 hold `req` high for 8 ops. Grant order is 0,1,2,3,0,1,2,3, with `done` spaced exactly 4 cycles apart.
- Bounds: CLAIM at addr 100 with `GRID_CELLS`=100. No `mem_re`/`mem_we` at any point; `ok`=0.
- FREE then CLAIM: FREE addr 23, then CLAIM addr 23 with wdata 8. The claim succeeds and the cell holds 8.
- Reset mid-claim: deassert `reset` during CHECK before the edge. No `mem_we`, all outputs 0, and the cell is unchanged.
